// File: rtl/boot_pkg.sv
// Shared constants for the boot master: register map, strobe codes,
// FSM state encoding and a helper that formats the target address word.
package boot_pkg;

  // Boot register responder offsets
  localparam logic [3:0] REG_SPI_ADDR = 4'h0;
  localparam logic [3:0] REG_REBOOT   = 4'h1;
  localparam logic [3:0] REG_KEY      = 4'h2;

  // Byte strobe codes: full-word write or read
  localparam logic [3:0] WSTRB_WR = 4'hF;
  localparam logic [3:0] WSTRB_RD = 4'h0;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_ADDR = 3'd1;
  localparam logic [2:0] ST_RD_ADDR = 3'd2;
  localparam logic [2:0] ST_WR_BOOT = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;
  localparam logic [2:0] ST_ERR     = 3'd5;

  // Zero-extend a 25-bit flash address onto the 32-bit data bus
  function automatic logic [31:0] tgt_word(input logic [24:0] tgt);
    return {7'd0, tgt};
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer followed by a level debouncer: the output follows
// the synchronized key only after it has disagreed for DEBOUNCE_CYCLES
// consecutive cycles; any agreeing cycle restarts the count.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic mem_clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_db
);

  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic        sync1_r;
  logic        sync2_r;
  logic        db_r;
  logic [15:0] cnt_r;

  // Bring the asynchronous key level into the mem_clk domain
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= key_in;
      sync2_r <= sync1_r;
    end
  end

  // Accept a new level only after it has been stable long enough
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      db_r  <= 1'b0;
      cnt_r <= 16'd0;
    end else if (sync2_r != db_r) begin
      if (cnt_r == CNT_LAST) begin
        db_r  <= sync2_r;
        cnt_r <= 16'd0;
      end else begin
        cnt_r <= cnt_r + 16'd1;
      end
    end else begin
      cnt_r <= 16'd0;
    end
  end

  assign key_db = db_r;

endmodule

// File: rtl/boot_master.sv
// Boot master: on a debounced key press or a software start it programs the
// selected flash image address into the boot responder, reads it back to
// verify, then writes the reboot command. Every bus request is time-limited.
module boot_master
  import boot_pkg::*;
#(
  parameter logic [24:0] IMG0_ADDR       = 25'h000000,
  parameter logic [24:0] IMG1_ADDR       = 25'h080000,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic        mem_clk,
  input  logic        rst_n,
  input  logic        key_in,
  input  logic        start,
  input  logic        img_sel,
  output logic        mem_valid,
  output logic [3:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT_CYCLES - 1);
  // Long enough for a key held through reset to reach key_db first
  localparam logic [16:0] SETTLE_LAST = 17'(DEBOUNCE_CYCLES + 3);

  logic [2:0]  state_r;
  logic [24:0] tgt_r;
  logic [15:0] tmo_cnt_r;
  logic        key_db_s;
  logic        key_prev_r;
  logic        armed_r;
  logic [16:0] settle_cnt_r;
  logic        trigger_s;
  logic        timeout_s;
  logic        rd_ok_s;
  logic [24:0] sel_tgt_s;
  logic [3:0]  req_addr_s;
  logic [31:0] req_wdata_s;
  logic [3:0]  req_wstrb_s;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .mem_clk(mem_clk),
    .rst_n  (rst_n),
    .key_in (key_in),
    .key_db (key_db_s)
  );

  // Key edge detection; the key only arms once seen released after reset
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      key_prev_r   <= 1'b0;
      armed_r      <= 1'b0;
      settle_cnt_r <= 17'd0;
    end else begin
      key_prev_r <= key_db_s;
      if (settle_cnt_r != SETTLE_LAST) begin
        settle_cnt_r <= settle_cnt_r + 17'd1;
      end else begin
        settle_cnt_r <= settle_cnt_r;
      end
      if ((settle_cnt_r == SETTLE_LAST) && !key_db_s) begin
        armed_r <= 1'b1;
      end else begin
        armed_r <= armed_r;
      end
    end
  end

  // Trigger, timeout and read-back decode
  always_comb begin
    trigger_s = start | (key_db_s & ~key_prev_r & armed_r);
    timeout_s = (tmo_cnt_r == TMO_LAST);
    rd_ok_s   = (mem_rdata[31:25] == 7'd0) && (mem_rdata[24:0] == tgt_r);
    if (img_sel) begin
      sel_tgt_s = IMG1_ADDR;
    end else begin
      sel_tgt_s = IMG0_ADDR;
    end
  end

  // Bus request contents for the transaction owned by each state
  always_comb begin
    req_addr_s  = 4'h0;
    req_wdata_s = 32'h0;
    req_wstrb_s = 4'h0;
    case (state_r)
      ST_WR_ADDR: begin
        req_addr_s  = REG_SPI_ADDR;
        req_wdata_s = tgt_word(tgt_r);
        req_wstrb_s = WSTRB_WR;
      end
      ST_RD_ADDR: begin
        req_addr_s  = REG_SPI_ADDR;
        req_wdata_s = 32'h0;
        req_wstrb_s = WSTRB_RD;
      end
      ST_WR_BOOT: begin
        req_addr_s  = REG_REBOOT;
        req_wdata_s = 32'h1;
        req_wstrb_s = WSTRB_WR;
      end
      default: begin
        req_addr_s  = 4'h0;
        req_wdata_s = 32'h0;
        req_wstrb_s = 4'h0;
      end
    endcase
  end

  // Sequencer FSM with registered bus and status outputs
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      tgt_r     <= 25'd0;
      tmo_cnt_r <= 16'd0;
      mem_valid <= 1'b0;
      mem_addr  <= 4'h0;
      mem_wdata <= 32'h0;
      mem_wstrb <= 4'h0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (trigger_s) begin
            // The first request goes out straight from acceptance
            state_r   <= ST_WR_ADDR;
            tgt_r     <= sel_tgt_s;
            error     <= 1'b0;
            busy      <= 1'b1;
            mem_valid <= 1'b1;
            mem_addr  <= REG_SPI_ADDR;
            mem_wdata <= tgt_word(sel_tgt_s);
            mem_wstrb <= WSTRB_WR;
            tmo_cnt_r <= 16'd0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WR_ADDR, ST_RD_ADDR, ST_WR_BOOT: begin
          if (!mem_valid) begin
            // Entering with valid low guarantees the inter-transaction gap
            mem_valid <= 1'b1;
            mem_addr  <= req_addr_s;
            mem_wdata <= req_wdata_s;
            mem_wstrb <= req_wstrb_s;
            tmo_cnt_r <= 16'd0;
          end else if (mem_ready) begin
            // Ready wins over a timeout landing on the same cycle
            mem_valid <= 1'b0;
            mem_addr  <= 4'h0;
            mem_wdata <= 32'h0;
            mem_wstrb <= 4'h0;
            tmo_cnt_r <= 16'd0;
            if (state_r == ST_WR_ADDR) begin
              state_r <= ST_RD_ADDR;
            end else if (state_r == ST_RD_ADDR) begin
              if (rd_ok_s) begin
                state_r <= ST_WR_BOOT;
              end else begin
                state_r <= ST_ERR;
                error   <= 1'b1;
              end
            end else begin
              state_r <= ST_DONE;
              done    <= 1'b1;
            end
          end else if (timeout_s) begin
            mem_valid <= 1'b0;
            mem_addr  <= 4'h0;
            mem_wdata <= 32'h0;
            mem_wstrb <= 4'h0;
            tmo_cnt_r <= 16'd0;
            state_r   <= ST_ERR;
            error     <= 1'b1;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 16'd1;
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        ST_ERR: begin
          error   <= 1'b1;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r   <= ST_IDLE;
          mem_valid <= 1'b0;
          mem_addr  <= 4'h0;
          mem_wdata <= 32'h0;
          mem_wstrb <= 4'h0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/boot_master.md
BOOT_MASTER -- requirements
Module: boot_master

Interface
REQ-001 The block SHALL expose parameter IMG0_ADDR, 25'h000000, SPI flash address of golden image.
REQ-002 The block SHALL expose parameter IMG1_ADDR, 25'h080000, SPI flash address of update image.
REQ-003 The block SHALL expose parameter DEBOUNCE_CYCLES, 16, number of stable mem_clk cycles before the key level is accepted (range 2..65535).
REQ-004 The block SHALL expose parameter TIMEOUT_CYCLES, 255, maximum cycles mem_valid may wait for mem_ready (range 1..65535).
REQ-005 mem_clk  input  1  bus clock; all logic is rising-edge on mem_clk.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 key_in  input  1  raw reboot push-button, asynchronous to mem_clk, active-high.
REQ-008 start  input  1  single-cycle software trigger.
REQ-009 img_sel  input  1  image select: 0 = IMG0_ADDR, 1 = IMG1_ADDR.
REQ-010 mem_valid  output  1  bus request to the boot register responder.
REQ-011 mem_addr  output  4  register offset.
REQ-012 mem_wdata  output  32  write data.
REQ-013 mem_wstrb  output  4  byte strobes; 4'hF = write, 4'h0 = read.
REQ-014 mem_ready  input  1  responder completion.
REQ-015 mem_rdata  input  32  read data, valid when mem_ready is high.
REQ-016 busy  output  1  high from trigger acceptance until DONE/ERR exit.
REQ-017 done  output  1  one-cycle pulse on successful sequence completion.
REQ-018 error  output  1  sticky failure flag.

Function
REQ-019 key_in SHALL pass a 2-flop synchronizer; key_db SHALL change only after the synchronized level differs from key_db for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free cycle restarts the count.
REQ-020 A trigger SHALL be a key_db 0->1 edge or start=1, accepted only in IDLE; simultaneous key and start SHALL launch one sequence; triggers outside IDLE SHALL be dropped.
REQ-021 On acceptance, img_sel SHALL be latched into target address TGT (25 bits, zero-extended to 32 on mem_wdata); error SHALL clear.
REQ-022 FSM states: IDLE, WR_ADDR, RD_ADDR, WR_BOOT, DONE, ERR.
REQ-023 IDLE -> WR_ADDR on trigger; WR_ADDR writes TGT to offset 4'h0; RD_ADDR reads offset 4'h0; WR_BOOT writes 32'h1 to offset 4'h1.
REQ-024 Handshake: mem_valid/mem_addr/mem_wdata/mem_wstrb SHALL be registered and held constant until the cycle mem_ready is sampled high; mem_valid SHALL be low for at least one cycle between transactions.
REQ-025 First request SHALL assert on the cycle after trigger acceptance; a responder with mem_ready = mem_valid yields a full sequence of 6 cycles from trigger to done.
REQ-026 When not requesting, mem_valid SHALL be 0 and mem_addr/mem_wdata/mem_wstrb SHALL be 0.
REQ-027 RD_ADDR completion SHALL compare mem_rdata[24:0] with TGT; match -> WR_BOOT, mismatch or nonzero mem_rdata[31:25] -> ERR.
REQ-028 A per-transaction counter SHALL clear at each request start; reaching TIMEOUT_CYCLES with mem_ready low SHALL drop mem_valid and enter ERR.
REQ-029 mem_ready arriving in the same cycle the counter reaches TIMEOUT_CYCLES SHALL count as success.
REQ-030 DONE SHALL pulse done for one cycle then return to IDLE; ERR SHALL set error, hold it, then return to IDLE next cycle.
REQ-031 mem_ready while mem_valid is low SHALL be ignored.

Reset
REQ-032 Reset SHALL force IDLE, mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, busy=0, done=0, error=0, key_db=0, synchronizer=0, counters=0.
REQ-033 Reset mid-transaction SHALL drop mem_valid asynchronously; no transaction resumes after release.
REQ-034 A key held high through reset release SHALL NOT trigger until released and re-pressed.

Structure
REQ-035 Package boot_pkg SHALL hold REG_SPI_ADDR=4'h0, REG_REBOOT=4'h1, REG_KEY=4'h2, WSTRB_WR=4'hF, WSTRB_RD=4'h0 and the FSM state encoding.
REQ-036 Synchronizer plus debounce SHALL be sub-module key_debounce (params DEBOUNCE_CYCLES; ports mem_clk, rst_n, key_in, key_db).

Verification
REQ-037 start=1, img_sel=1, responder ready=valid echoing writes -> writes 0x00080000@0, read 0x00080000@0, writes 0x1@1, done pulses at cycle 6, error=0.
REQ-038 key_in pulse of 10 cycles with DEBOUNCE_CYCLES=16 -> no mem_valid; held 40 cycles -> exactly one sequence.
REQ-039 Responder returns 0x00000000 on read, img_sel=1 -> ERR, error=1, no write to offset 4'h1.
REQ-040 mem_ready never asserted, TIMEOUT_CYCLES=8 -> mem_valid high 8 cycles then low, error=1, busy=0.
REQ-041 start during active sequence, and rst_n low during WR_ADDR -> second trigger ignored; reset drops mem_valid immediately, all outputs 0.
